// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// parameter defaults and a small address-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          TIMEOUT_DEFAULT  = 16;

    // Instructions are word aligned; any set low bit in a target is illegal.
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// Pending-redirect register: remembers a branch target requested while no PC
// write was happening, so it can be applied at the next PC write.
module fetch_redirect_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        pc_we,
    output logic        pending,
    output logic [31:0] target
);

    // A PC write consumes any pending redirect; otherwise the latest branch wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            target  <= 32'h0;
        end else if (pc_we) begin
            pending <= 1'b0;
        end else if (br_valid) begin
            pending <= 1'b1;
            target  <= br_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. Requests instructions, offers them to decode,
// parks a word in a hold register while decode stalls, computes the next PC
// (with a one-instruction delay slot for redirects) and flags fetch errors.
//
// Handshake to decode: an instruction is offered when instr_valid=1 and is
// accepted in any cycle where instr_valid=1 and stall_d=0; the offered word
// must stay stable until accepted, which the hold register guarantees.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        im_ready,
    input  logic        stall_d,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic        pc_we,
    output logic [31:0] npc,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt,
    output state_t      dbg_state
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hold_q;
    logic [15:0] wait_cnt;
    logic        latch_hold;
    logic        bad_br;
    logic        redir_pending;
    logic [31:0] redir_target;

    assign bad_br    = br_valid && misaligned(br_target);
    assign dbg_state = state;

    fetch_redirect_buf u_redirect (
        .clk      (clk),
        .reset    (reset),
        .br_valid (br_valid),
        .br_target(br_target),
        .pc_we    (pc_we),
        .pending  (redir_pending),
        .target   (redir_target)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-state outputs; a bad branch target wins over everything.
    always_comb begin
        state_nxt   = state;
        im_req      = 1'b0;
        instr_valid = 1'b0;
        instr_out   = 32'h0;
        pc_we       = 1'b0;
        latch_hold  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = bad_br ? ERR : FETCH;
            end
            FETCH: begin
                im_req      = 1'b1;
                instr_valid = im_ready;
                instr_out   = instr_in;
                if (bad_br) begin
                    state_nxt = ERR;
                end else if (im_ready) begin
                    if (!stall_d) begin
                        pc_we = 1'b1;
                    end else begin
                        latch_hold = 1'b1;
                        state_nxt  = HOLD;
                    end
                end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                instr_out   = hold_q;
                if (bad_br) begin
                    state_nxt = ERR;
                end else if (!stall_d) begin
                    pc_we     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next PC: a redirect this cycle beats a pending one, which beats sequential.
    always_comb begin
        if (reset)              npc = RESET_PC;
        else if (br_valid)      npc = br_target;
        else if (redir_pending) npc = redir_target;
        else                    npc = pc_in + 32'd4;
    end

    // Consecutive memory-wait cycles while fetching; cleared otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       wait_cnt <= 16'h0;
        else if (state == FETCH && !im_ready) wait_cnt <= wait_cnt + 16'd1;
        else                             wait_cnt <= 16'h0;
    end

    // Hold register captures the word decode could not take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           hold_q <= 32'h0;
        else if (latch_hold) hold_q <= instr_in;
    end

    // Accepted-instruction counter, free running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      fetch_cnt <= 32'h0;
        else if (pc_we) fetch_cnt <= fetch_cnt + 32'd1;
    end

    // Sticky error flag, set on any transition into the error state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 fetch_err <= 1'b0;
        else if (state_nxt == ERR) fetch_err <= 1'b1;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int          TO  = 16;
  localparam bit          Y   = 1'b1;
  localparam bit          N   = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc_in = RPC;
  logic [31:0] instr_in = 32'h0;
  logic        im_ready = 1'b0;
  logic        stall_d = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        im_req;
  logic        pc_we;
  logic [31:0] npc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  state_t      dbg_state;

  fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .im_ready(im_ready), .stall_d(stall_d), .br_valid(br_valid),
    .br_target(br_target), .im_req(im_req), .pc_we(pc_we), .npc(npc),
    .instr_valid(instr_valid), .instr_out(instr_out), .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase of the fetcher as plain flags: waiting for first edge, parked on a
  // stalled word, or dead after an error.
  bit          m_started, m_holding, m_dead, m_pend;
  logic [31:0] m_held, m_ptgt, m_cnt, m_pc;
  int          m_wait;
  bit          e_req, e_valid, e_we, e_bad;
  logic [31:0] e_out, e_npc;
  state_t      e_state;

  task automatic model_reset();
    m_started = 0; m_holding = 0; m_dead = 0; m_pend = 0;
    m_held = 32'h0; m_ptgt = 32'h0; m_cnt = 32'h0; m_pc = RPC; m_wait = 0;
  endtask

  task automatic model_eval();
    logic [31:0] t;
    t = br_target;
    e_bad   = br_valid && (t[1:0] != 2'b00) && !m_dead;
    e_req   = m_started && !m_holding && !m_dead;
    e_valid = m_started && !m_dead && (m_holding || im_ready);
    e_out   = m_holding ? m_held : instr_in;
    e_we    = m_started && !m_dead && !e_bad && !stall_d && (m_holding || im_ready);
    e_npc   = br_valid ? br_target : (m_pend ? m_ptgt : m_pc + 32'd4);
    if (m_dead)          e_state = ERR;
    else if (!m_started) e_state = IDLE;
    else if (m_holding)  e_state = HOLD;
    else                 e_state = FETCH;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_and_check(input bit ir, input bit st, input bit br,
                                 input logic [31:0] tgt, input logic [31:0] ins);
    @(negedge clk);
    im_ready = ir; stall_d = st; br_valid = br; br_target = tgt;
    instr_in = ins; pc_in = m_pc;
    #1;
    model_eval();
    check1("im_req", im_req, e_req);
    check1("instr_valid", instr_valid, e_valid);
    if (m_started && !m_dead) check32("instr_out", instr_out, e_out);
    check1("pc_we", pc_we, e_we);
    if (e_we) check32("npc", npc, e_npc);
    check1("fetch_err", fetch_err, m_dead);
    check32("fetch_cnt", fetch_cnt, m_cnt);
    check32("state", 32'(dbg_state), 32'(e_state));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!m_dead) begin
      if (e_bad) m_dead = 1;
      else if (!m_started) m_started = 1;
      else if (m_holding) begin
        if (!stall_d) m_holding = 0;
      end else if (im_ready) begin
        m_wait = 0;
        if (stall_d) begin m_holding = 1; m_held = instr_in; end
      end else begin
        m_wait++;
        if (m_wait == TO) m_dead = 1;
      end
    end
    if (e_we) begin
      m_pend = 0; m_cnt = m_cnt + 32'd1; m_pc = e_npc;
    end else if (br_valid) begin
      m_pend = 1; m_ptgt = br_target;
    end
  endtask

  task automatic step(input bit ir, input bit st, input bit br,
                      input logic [31:0] tgt, input logic [31:0] ins);
    drive_and_check(ir, st, br, tgt, ins);
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    br_valid = 1'b0; pc_in = RPC;
    reset = 1'b1;
    #1;
    check1("rst_im_req", im_req, 1'b0);
    check1("rst_pc_we", pc_we, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check32("rst_instr_out", instr_out, 32'h0);
    check1("rst_fetch_err", fetch_err, 1'b0);
    check32("rst_fetch_cnt", fetch_cnt, 32'h0);
    check32("rst_npc", npc, RPC);
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          ir, st, br;
    logic [31:0] tgt, ins;
    bit          e_we, e_valid, e_req;
    logic [31:0] e_npc, e_out, e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int burst;
    // Sequential run, a 3-cycle decode stall, a delayed redirect, a
    // latest-wins redirect and a redirect coincident with an accept.
    tbl[0]  = '{Y, N, N, 32'h0,    32'h11,        N, N, N, 32'h0,    32'h0,         32'd0};
    tbl[1]  = '{Y, N, N, 32'h0,    32'h11,        Y, Y, Y, 32'h3004, 32'h11,        32'd0};
    tbl[2]  = '{Y, N, N, 32'h0,    32'h12,        Y, Y, Y, 32'h3008, 32'h12,        32'd1};
    tbl[3]  = '{Y, N, N, 32'h0,    32'h13,        Y, Y, Y, 32'h300C, 32'h13,        32'd2};
    tbl[4]  = '{Y, Y, N, 32'h0,    32'h2408_0005, N, Y, Y, 32'h0,    32'h2408_0005, 32'd3};
    tbl[5]  = '{Y, Y, N, 32'h0,    32'hDEAD_BEEF, N, Y, N, 32'h0,    32'h2408_0005, 32'd3};
    tbl[6]  = '{Y, Y, N, 32'h0,    32'hDEAD_BEEF, N, Y, N, 32'h0,    32'h2408_0005, 32'd3};
    tbl[7]  = '{Y, N, N, 32'h0,    32'hDEAD_BEEF, Y, Y, N, 32'h3010, 32'h2408_0005, 32'd3};
    tbl[8]  = '{N, N, Y, 32'h3100, 32'h55,        N, N, Y, 32'h0,    32'h0,         32'd4};
    tbl[9]  = '{Y, N, N, 32'h0,    32'h66,        Y, Y, Y, 32'h3100, 32'h66,        32'd4};
    tbl[10] = '{Y, N, N, 32'h0,    32'h77,        Y, Y, Y, 32'h3104, 32'h77,        32'd5};
    tbl[11] = '{N, N, Y, 32'h3100, 32'h88,        N, N, Y, 32'h0,    32'h0,         32'd6};
    tbl[12] = '{N, N, Y, 32'h3200, 32'h88,        N, N, Y, 32'h0,    32'h0,         32'd6};
    tbl[13] = '{Y, N, N, 32'h0,    32'h99,        Y, Y, Y, 32'h3200, 32'h99,        32'd6};
    tbl[14] = '{Y, N, Y, 32'h3300, 32'hAA,        Y, Y, Y, 32'h3300, 32'hAA,        32'd7};
    tbl[15] = '{Y, N, N, 32'h0,    32'hBB,        Y, Y, Y, 32'h3304, 32'hBB,        32'd8};

    model_reset();
    apply_reset();

    for (int i = 0; i < 16; i++) begin
      drive_and_check(tbl[i].ir, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].ins);
      check1("tbl_pc_we", pc_we, tbl[i].e_we);
      check1("tbl_valid", instr_valid, tbl[i].e_valid);
      check1("tbl_im_req", im_req, tbl[i].e_req);
      check32("tbl_cnt", fetch_cnt, tbl[i].e_cnt);
      if (tbl[i].e_we) check32("tbl_npc", npc, tbl[i].e_npc);
      if (tbl[i].e_valid) check32("tbl_out", instr_out, tbl[i].e_out);
      advance();
    end

    // Timeout: 16 consecutive cycles without im_ready kills the fetcher.
    apply_reset();
    step(1, 0, 0, 32'h0, 32'h1);
    for (int i = 0; i < TO; i++) begin
      drive_and_check(0, 0, 0, 32'h0, 32'h2);
      if (i == TO - 1) check1("to_err_before", fetch_err, 1'b0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive_and_check(1, 0, 0, 32'h0, 32'h3);
      check1("to_err", fetch_err, 1'b1);
      check1("to_im_req", im_req, 1'b0);
      check1("to_pc_we", pc_we, 1'b0);
      check32("to_state", 32'(dbg_state), 32'(ERR));
      advance();
    end
    apply_reset();

    // Reset while parked in HOLD.
    step(1, 0, 0, 32'h0, 32'h4);
    step(1, 1, 0, 32'h0, 32'hCAFE_F00D);
    drive_and_check(1, 1, 0, 32'h0, 32'h5);
    check32("hold_out", instr_out, 32'hCAFE_F00D);
    advance();
    apply_reset();

    // Misaligned redirect target: no PC write, error on the next edge.
    step(1, 0, 0, 32'h0, 32'h6);
    step(1, 0, 0, 32'h0, 32'h7);
    drive_and_check(1, 0, 1, 32'h3102, 32'h8);
    check1("mis_pc_we", pc_we, 1'b0);
    advance();
    drive_and_check(1, 0, 0, 32'h0, 32'h9);
    check1("mis_err", fetch_err, 1'b1);
    check32("mis_state", 32'(dbg_state), 32'(ERR));
    advance();
    apply_reset();

    // Randomized traffic against the model.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit ir, st, br;
      logic [31:0] tgt;
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        burst = 0;
      end else begin
        if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(10, 20);
        if (burst > 0) begin
          ir = 0;
          burst--;
        end else begin
          ir = ($urandom_range(0, 9) < 7);
        end
        st  = ($urandom_range(0, 3) == 0);
        br  = ($urandom_range(0, 11) == 0);
        tgt = 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 99) == 0) tgt = tgt + 32'($urandom_range(1, 3));
        step(ir, st, br, tgt, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, the maximum consecutive FETCH cycles without im_ready before an error.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pc_in, input, 32, the current PC from the PC/instruction-memory unit.
REQ-006 The block SHALL have port instr_in, input, 32, the instruction word read at pc_in.
REQ-007 The block SHALL have port im_ready, input, 1, meaning instr_in is valid this cycle.
REQ-008 The block SHALL have port stall_d, input, 1, meaning decode cannot accept an instruction this cycle.
REQ-009 The block SHALL have port br_valid, input, 1, a one-cycle redirect request from decode.
REQ-010 The block SHALL have port br_target, input, 32, the redirect address, sampled when br_valid=1.
REQ-011 The block SHALL have port im_req, output, 1, the fetch request to instruction memory.
REQ-012 The block SHALL have port pc_we, output, 1, the PC write enable.
REQ-013 The block SHALL have port npc, output, 32, the next PC, meaningful when pc_we=1.
REQ-014 The block SHALL have port instr_valid, output, 1, meaning instr_out is offered to decode.
REQ-015 The block SHALL have port instr_out, output, 32, the instruction offered to decode.
REQ-016 The block SHALL have port fetch_err, output, 1, a sticky error flag.
REQ-017 The block SHALL have port fetch_cnt, output, 32, the count of instructions accepted by decode.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, HOLD and ERR; after reset the state SHALL be IDLE, with IDLE->FETCH unconditionally on the next edge.
REQ-019 In FETCH, im_req SHALL be 1; instr_valid SHALL equal im_ready, and instr_out SHALL equal instr_in, combinationally.
REQ-020 In FETCH with im_ready=1 and stall_d=0, an accept SHALL occur: pc_we=1 that cycle, fetch_cnt increments at the edge, and the state stays FETCH.
REQ-021 In FETCH with im_ready=1 and stall_d=1, instr_in SHALL be latched into a hold register and the state SHALL move to HOLD.
REQ-022 In HOLD, im_req SHALL be 0, instr_valid SHALL be 1, and instr_out SHALL be the hold register.
REQ-023 In HOLD with stall_d=0, an accept SHALL occur (pc_we=1, fetch_cnt++) and the state SHALL return to FETCH.
REQ-024 npc SHALL be selected by priority: br_target if br_valid=1 this cycle, else the pending redirect target if one is pending, else pc_in+4 (mod 2^32).
REQ-025 A br_valid not coincident with pc_we SHALL set the redirect-pending flag and store br_target.
REQ-026 A later br_valid SHALL overwrite the pending redirect target (latest wins).
REQ-027 pc_we SHALL clear the redirect-pending flag.
REQ-028 The redirect SHALL apply to the PC after the instruction currently in fetch, which implements the delay slot: the in-fetch instruction is never discarded.
REQ-029 In FETCH, a wait counter SHALL count cycles with im_ready=0 and reset to 0 on im_ready=1 or on leaving FETCH.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL set fetch_err and enter ERR.
REQ-031 br_valid with br_target[1:0]!=0 SHALL set fetch_err and enter ERR on the next edge, without writing the PC.
REQ-032 ERR SHALL be terminal until reset; in ERR, im_req=pc_we=instr_valid=0.
REQ-033 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-034 Asserting reset at any time, including mid-FETCH or in HOLD, SHALL immediately force: state IDLE; im_req=0; pc_we=0; instr_valid=0; instr_out=0; fetch_err=0; fetch_cnt=0; redirect pending cleared with target 0; wait counter 0; hold register 0.
REQ-035 While reset is asserted, npc SHALL equal RESET_PC.

Structure
REQ-036 The state encoding, RESET_PC default and TIMEOUT default SHALL reside in shared package fetch_pkg.
REQ-037 The pending-redirect register (flag, target and overwrite/clear logic) SHALL be the single sub-module fetch_redirect_buf; the FSM, counters and hold register SHALL stay in fetch_ctrl.

Verification
REQ-038 Release reset, with im_ready=1 and stall_d=0 constantly, and pc_in following npc -> IDLE for 1 cycle, then pc_we=1 every cycle, with npc 0x3004, 0x3008, ... and fetch_cnt incrementing by 1 per cycle.
REQ-039 Apply stall_d=1 for 3 cycles while instr_in=0x2408_0005 -> HOLD, instr_out=0x2408_0005 held for 3 cycles with pc_we=0, then one accept and a return to FETCH.
REQ-040 Pulse br_valid with target 0x3100 while im_ready=0 -> no pc_we that cycle; the next accept drives npc=0x3100 and the following accept drives 0x3104.
REQ-041 Pulse br_valid with 0x3100 then with 0x3200 before any accept -> the next npc is 0x3200.
REQ-042 Hold im_ready=0 for 16 cycles with TIMEOUT=16 -> fetch_err=1, state ERR, im_req=0; asserting reset clears everything.
REQ-043 Pulse br_valid with br_target=0x3102 -> fetch_err=1 and no PC write.
